piso_tx_block: RTL and testbench
================================

Name: piso_tx_block

Overview:
- Parallel-in, serial-out transmitter in the Serial Interface Engine; the transmit-side counterpart of the byte deserializer.
- Accepts bytes over a valid/ready handshake and shifts them out LSB-first, one bit per clk.
- Optionally inserts a 0 after a configurable run of consecutive 1s (bit stuffing).
- The resulting stream, with the stuffed bits removed, is the stream that the receive-side deserializer reassembles into the same byte values.

Parameters:
- DATA_W, 8: parallel word width in bits.
- STUFF_EN, 1: 1 enables bit stuffing; 0 sends the stream unmodified.
- STUFF_RUN, 6: number of consecutive transmitted 1s that triggers one stuffed 0. Legal range is 2..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- par_ip  input  DATA_W  byte to transmit; sampled only on an accepted handshake.
- par_valid  input  1  par_ip holds a byte to send.
- par_ready  output  1  block can accept par_ip in this cycle.
- ser_op  output  1  serial data out, registered.
- ser_en  output  1  ser_op carries a valid bit (data or stuffed), registered.
- stuff_flag  output  1  the current ser_op bit is a stuffed 0, registered.
- byte_done  output  1  one-cycle pulse, registered; the last data bit of a byte is on ser_op this cycle.

Behaviour:
- Reset (asynchronous on rst high): state=IDLE, shift register=0, bit_cnt=0, ones_cnt=0, ser_op=1 (idle level), ser_en=0, stuff_flag=0, byte_done=0. par_ready is forced to 0 while rst is high.
- Reset mid-byte: the remaining bits are dropped, the line returns to idle immediately, and no byte_done is produced.
- Handshake:
  - A byte is accepted on a rising edge where par_valid && par_ready.
  - par_ip is latched into the shift register and bit_cnt is set to 0.
  - par_valid may stay high across bytes; par_ready has no combinational path from par_valid.
- Latency: a byte accepted at edge N drives bit0 on ser_op (with ser_en=1) during cycle N+1. Bit k appears at cycle N+1+k plus any stuffed bits inserted before it.
- States:
  - IDLE: ser_en=0, ser_op=1, par_ready=1, ones_cnt cleared. On accept, go to SHIFT.
  - SHIFT:
    - Each cycle drives ser_op = shift register bit0 and shifts right.
    - ones_cnt increments on a 1 and clears on a 0.
    - If STUFF_EN and the bit just driven makes ones_cnt==STUFF_RUN, the next state is STUFF.
    - Otherwise, after bit DATA_W-1, the next state is SHIFT (new byte accepted) or IDLE (no byte).
  - STUFF: drives ser_op=0, stuff_flag=1, ser_en=1 for exactly one cycle and clears ones_cnt. It then resumes the remaining bits in SHIFT, or goes to SHIFT/IDLE as above if the stuff bit followed the last data bit.
- par_ready:
  - 1 in IDLE.
  - 1 in the SHIFT cycle driving bit DATA_W-1, unless that bit triggers a stuff.
  - 1 in a STUFF cycle that follows bit DATA_W-1.
  - 0 otherwise.
  - Result: back-to-back bytes are sent with no idle gap.
- ones_cnt carries across back-to-back bytes and is cleared only by a 0 bit, a stuff bit, IDLE, or reset.
- Width rules: bit_cnt is $clog2(DATA_W) bits wide; ones_cnt is 4 bits wide.
- byte_done: asserted with the ser_op cycle carrying data bit DATA_W-1. A following stuff bit does not delay it.
- STUFF_EN=0: the STUFF state is unreachable and stuff_flag is constantly 0.
- A handshake attempted while par_ready=0 has no effect; par_ip is ignored.

Decomposition:
- Shared package sie_pkg holds:
  - the state enum tx_state_t (IDLE, SHIFT, STUFF);
  - the constants SIE_IDLE_LVL=1'b1 and SIE_STUFF_RUN_DEF=6.
- Sub-module stuff_ctr: the ones-run counter plus stuff-request compare, reusable by the receive-side destuffer.
- Everything else stays in one always_ff FSM.

Test Plan:
- Reset mid-byte: accept 8'hA5, assert rst after 3 bits -> ser_op=1, ser_en=0 immediately; byte_done never pulses; after release, par_ready=1.
- Single byte, no stuffing: 8'hA5 accepted at edge N -> ser_op = 1,0,1,0,0,1,0,1 in cycles N+1..N+8 with ser_en=1; byte_done in cycle N+8; IDLE in cycle N+9.
- Back-to-back: par_valid held high with 8'h0F then 8'hF0 -> 16 contiguous ser_en cycles, no gap; par_ready high in cycles N+8 and N+16.
- Stuffing inside a byte: 8'h3F (six 1s first) -> 1,1,1,1,1,1,0(stuff_flag=1),0,0; 9 ser_en cycles; byte_done on the final bit.
- Stuffing across bytes: 8'hE0 then 8'h07 (three 1s plus three 1s) -> stuffed 0 inserted after the 3rd bit of the second byte; ones_cnt carries across the byte boundary.
- STUFF_EN=0 with 8'hFF x2 -> 16 consecutive 1s, stuff_flag never asserted; loopback into the deserializer yields 8'hFF, 8'hFF.

Source files
------------

// File: rtl/sie_pkg.sv
// Shared types and constants for the Serial Interface Engine transmit and receive paths.
package sie_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      STUFF
   } tx_state_t;

   localparam logic        SIE_IDLE_LVL      = 1'b1;
   localparam int unsigned SIE_STUFF_RUN_DEF = 6;

endpackage

// File: rtl/stuff_ctr.sv
// Ones-run counter with stuff request; the count includes the bit currently on the line.
module stuff_ctr
   import sie_pkg::*;
#(
   parameter int unsigned STUFF_EN  = 1,
   parameter int unsigned STUFF_RUN = SIE_STUFF_RUN_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic bit_en,
   input  logic bit_in,
   output logic stuff_req
);

   logic [3:0] ones_q, ones_d;

   always_comb begin
      ones_d = ones_q;
      if (clr) begin
         ones_d = 4'd0;
      end else if (bit_en) begin
         if (!bit_in) begin
            ones_d = 4'd0;
         end else if (ones_q != 4'hf) begin
            // Saturate so long runs with stuffing disabled cannot wrap.
            ones_d = ones_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ones_q <= 4'd0;
      end else begin
         ones_q <= ones_d;
      end
   end

   assign stuff_req = (STUFF_EN != 0) && (ones_q == 4'(STUFF_RUN));

endmodule

// File: rtl/piso_tx_block.sv
// Parallel-in serial-out transmitter: LSB-first, registered outputs, optional bit stuffing.
module piso_tx_block
   import sie_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned STUFF_EN  = 1,
   parameter int unsigned STUFF_RUN = SIE_STUFF_RUN_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] par_ip,
   input  logic              par_valid,
   output logic              par_ready,
   output logic              ser_op,
   output logic              ser_en,
   output logic              stuff_flag,
   output logic              byte_done
);

   localparam int unsigned     CW       = $clog2(DATA_W);
   localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_W - 1);

   // state_q describes what ser_op is showing right now.
   tx_state_t         state_q, state_d;
   logic [DATA_W-1:0] sr_q, sr_d;
   logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
   logic              ser_op_d, ser_en_d, stuff_d, done_d;
   logic              is_last, accept, load, adv;
   logic              ctr_clr, ctr_en, stuff_req;

   assign is_last = (bit_cnt_q == LAST_BIT);
   assign accept  = par_valid && par_ready;

   assign par_ready = !rst && ((state_q == IDLE) ||
                               (state_q == SHIFT && is_last && !stuff_req) ||
                               (state_q == STUFF && is_last));

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      bit_cnt_d = bit_cnt_q;
      ser_op_d  = SIE_IDLE_LVL;
      ser_en_d  = 1'b0;
      stuff_d   = 1'b0;
      done_d    = 1'b0;
      ctr_clr   = 1'b0;
      ctr_en    = 1'b0;
      load      = 1'b0;
      adv       = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) load = 1'b1;
         end
         SHIFT: begin
            if (stuff_req) begin
               state_d  = STUFF;
               ser_op_d = 1'b0;
               ser_en_d = 1'b1;
               stuff_d  = 1'b1;
               ctr_clr  = 1'b1;
            end else if (!is_last) begin
               adv = 1'b1;
            end else if (accept) begin
               load = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         STUFF: begin
            if (!is_last) begin
               adv = 1'b1;
            end else if (accept) begin
               load = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         sr_d      = par_ip;
         bit_cnt_d = '0;
         state_d   = SHIFT;
      end else if (adv) begin
         sr_d      = sr_q >> 1;
         bit_cnt_d = bit_cnt_q + 1'b1;
         state_d   = SHIFT;
      end

      if (load || adv) begin
         ser_op_d = sr_d[0];
         ser_en_d = 1'b1;
         done_d   = (bit_cnt_d == LAST_BIT);
         ctr_en   = 1'b1;
      end else if (state_d == IDLE) begin
         ctr_clr = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         sr_q       <= '0;
         bit_cnt_q  <= '0;
         ser_op     <= SIE_IDLE_LVL;
         ser_en     <= 1'b0;
         stuff_flag <= 1'b0;
         byte_done  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         bit_cnt_q  <= bit_cnt_d;
         ser_op     <= ser_op_d;
         ser_en     <= ser_en_d;
         stuff_flag <= stuff_d;
         byte_done  <= done_d;
      end
   end

   stuff_ctr #(
      .STUFF_EN  (STUFF_EN),
      .STUFF_RUN (STUFF_RUN)
   ) u_stuff_ctr (
      .clk       (clk),
      .rst       (rst),
      .clr       (ctr_clr),
      .bit_en    (ctr_en),
      .bit_in    (sr_d[0]),
      .stuff_req (stuff_req)
   );

endmodule

// File: tb/tb_piso_tx_block.sv
// Scoreboard bench: hand-computed serial streams queued at stimulus time, popped by monitors.
module tb_piso_tx_block;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] par_ip, p2_ip;
   logic       par_valid, p2_valid;
   logic       par_ready, ser_op, ser_en, stuff_flag, byte_done;
   logic       p2_ready, ser_op2, ser_en2, stuff_flag2, byte_done2;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic b;
      logic st;
      logic dn;
      logic rdy;
   } exp_t;

   exp_t       q[$];
   logic [7:0] exp2[$];
   exp_t       e;
   int         idx = 0;
   logic [7:0] sh2 = 8'h00;
   int         n2 = 0;
   int         run2 = 0;
   int         maxrun2 = 0;
   logic [7:0] want2;

   always #5 clk = ~clk;

   piso_tx_block #(.DATA_W(8), .STUFF_EN(1), .STUFF_RUN(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .par_ip     (par_ip),
      .par_valid  (par_valid),
      .par_ready  (par_ready),
      .ser_op     (ser_op),
      .ser_en     (ser_en),
      .stuff_flag (stuff_flag),
      .byte_done  (byte_done)
   );

   piso_tx_block #(.DATA_W(8), .STUFF_EN(0), .STUFF_RUN(6)) dut2 (
      .clk        (clk),
      .rst        (rst),
      .par_ip     (p2_ip),
      .par_valid  (p2_valid),
      .par_ready  (p2_ready),
      .ser_op     (ser_op2),
      .ser_en     (ser_en2),
      .stuff_flag (stuff_flag2),
      .byte_done  (byte_done2)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   // bits/st/dn/rdy are indexed by transmitted position, first bit at [0].
   task automatic push_vec(input logic [31:0] bits, input logic [31:0] st,
                           input logic [31:0] dn, input logic [31:0] rdy, input int n);
      exp_t x;
      for (int i = 0; i < n; i++) begin
         x.b   = bits[i];
         x.st  = st[i];
         x.dn  = dn[i];
         x.rdy = rdy[i];
         q.push_back(x);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int t = 0;
      par_ip    = b;
      par_valid = 1'b1;
      while (!par_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (!par_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout byte %0h never accepted", b);
      end else begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send2(input logic [7:0] b);
      int t = 0;
      p2_ip    = b;
      p2_valid = 1'b1;
      while (!p2_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (!p2_ready) begin
         checks++;
         errors++;
         $display("FAIL send2_timeout byte %0h never accepted", b);
      end else begin
         @(posedge clk); #1;
      end
   endtask

   task automatic drain(input string name);
      int t = 0;
      while (q.size() != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain %0d bits never appeared, want 0", name, q.size());
         q.delete();
      end
      repeat (3) @(posedge clk);
      #1;
      chk({name, "_idle_en"}, 32'(ser_en), 32'd0);
      chk({name, "_idle_op"}, 32'(ser_op), 32'd1);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (ser_en) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL extra_bit ser_op=%0b got a bit, want none", ser_op);
            end else begin
               e = q.pop_front();
               if ({ser_op, stuff_flag, byte_done, par_ready} !== {e.b, e.st, e.dn, e.rdy}) begin
                  errors++;
                  $display("FAIL stream_bit%0d op/stuff/done/ready got %b%b%b%b want %b%b%b%b",
                           idx, ser_op, stuff_flag, byte_done, par_ready,
                           e.b, e.st, e.dn, e.rdy);
               end
            end
            idx++;
         end else if (byte_done || stuff_flag) begin
            checks++;
            errors++;
            $display("FAIL idle_strobe done/stuff got %b%b want 00", byte_done, stuff_flag);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && ser_en2) begin
         checks++;
         if (stuff_flag2 !== 1'b0 || byte_done2 !== (n2 == 7)) begin
            errors++;
            $display("FAIL nostuff_flags stuff/done got %b%b want 0%b",
                     stuff_flag2, byte_done2, (n2 == 7));
         end
         run2 = ser_op2 ? run2 + 1 : 0;
         if (run2 > maxrun2) maxrun2 = run2;
         sh2 = {ser_op2, sh2[7:1]};
         n2++;
         if (n2 == 8) begin
            n2 = 0;
            checks++;
            if (exp2.size() == 0) begin
               errors++;
               $display("FAIL loopback_extra got %0h want none", sh2);
            end else begin
               want2 = exp2.pop_front();
               if (sh2 !== want2) begin
                  errors++;
                  $display("FAIL loopback_byte got %0h want %0h", sh2, want2);
               end
            end
         end
      end else if (!ser_en2) begin
         run2 = 0;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b1;
      par_ip    = 8'h00;
      par_valid = 1'b0;
      p2_ip     = 8'h00;
      p2_valid  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_op", 32'(ser_op), 32'd1);
      chk("rst_en", 32'(ser_en), 32'd0);
      chk("rst_stuff", 32'(stuff_flag), 32'd0);
      chk("rst_done", 32'(byte_done), 32'd0);
      chk("rst_ready", 32'(par_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 32'(par_ready), 32'd1);
      @(posedge clk); #1;

      // A5: 1,0,1,0,0,1,0,1
      push_vec(32'hA5, 32'h0, 32'h80, 32'h80, 8);
      send(8'hA5);
      par_valid = 1'b0;
      drain("single_a5");

      // 0F then F0 back-to-back, no stuffing
      push_vec(32'hF00F, 32'h0, 32'h8080, 32'h8080, 16);
      send(8'h0F);
      send(8'hF0);
      par_valid = 1'b0;
      drain("b2b_0f_f0");

      // 3F: six 1s, stuffed 0, then 0,0
      push_vec(32'h03F, 32'h040, 32'h100, 32'h100, 9);
      send(8'h3F);
      par_valid = 1'b0;
      drain("stuff_3f");

      // E0 then 07: run spans the byte boundary, stuff after 3rd bit of 07
      push_vec(32'h7E0, 32'h800, 32'h10080, 32'h10080, 17);
      send(8'hE0);
      send(8'h07);
      par_valid = 1'b0;
      drain("stuff_cross");

      // FC then 01: stuff follows the last data bit, ready moves to the stuff cycle
      push_vec(32'h2FC, 32'h100, 32'h10080, 32'h10100, 17);
      send(8'hFC);
      send(8'h01);
      par_valid = 1'b0;
      drain("stuff_last");

      // FF alone: six 1s, stuff, 1,1
      push_vec(32'h1BF, 32'h040, 32'h100, 32'h100, 9);
      send(8'hFF);
      par_valid = 1'b0;
      drain("stuff_ff");

      // Reset after three bits of A5: only 1,0,1 may appear
      push_vec(32'h5, 32'h0, 32'h0, 32'h0, 3);
      send(8'hA5);
      par_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_op", 32'(ser_op), 32'd1);
      chk("midrst_en", 32'(ser_en), 32'd0);
      chk("midrst_done", 32'(byte_done), 32'd0);
      chk("midrst_ready", 32'(par_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("midrst_release_ready", 32'(par_ready), 32'd1);
      chk("midrst_leftover", 32'(q.size()), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("midrst_quiet_en", 32'(ser_en), 32'd0);

      // Stuffing disabled: FF,FF as 16 contiguous 1s
      exp2.push_back(8'hFF);
      exp2.push_back(8'hFF);
      send2(8'hFF);
      send2(8'hFF);
      p2_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("nostuff_leftover", 32'(exp2.size()), 32'd0);
      chk("nostuff_run16", 32'(maxrun2), 32'd16);
      chk("nostuff_idle_en", 32'(ser_en2), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
